// File: rtl/ifetch.sv
// ifetch: byte-serial instruction fetch FSM (opcode byte + optional immediate) with ready/valid issue.
// IFETCH_ILLEGAL_TRAP_EN: halts with illegal=1 on opcodes 12-15 instead of issuing them.
module ifetch #(
  parameter logic [7:0] RESET_PC = 8'd0
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_data,
  input  logic       ins_ready,
  output logic       ins_valid,
  output logic [3:0] ins_opcode,
  output logic [1:0] ins_dst,
  output logic [1:0] ins_src,
  output logic [7:0] ins_imm,
  output logic       ins_has_imm,
  output logic [7:0] ins_pc,
  output logic       halted,
  output logic       illegal
);
  typedef enum logic [1:0] {FETCH_OP, FETCH_IMM, ISSUE, HALTED} state_t;
  state_t     r_state, w_next;
  logic [7:0] r_pc, r_imm, r_ins_pc;
  logic [3:0] r_opcode;
  logic [1:0] r_dst, r_src;
  logic       r_has_imm, r_illegal;
  logic       w_need_imm, w_trap;
  // HALT (3) and NOT (7) never carry an immediate even with src==0
  assign w_need_imm = rom_data[1:0] == 2'd0 && rom_data[7:4] != 4'd3 && rom_data[7:4] != 4'd7;
`ifdef IFETCH_ILLEGAL_TRAP_EN
  assign w_trap = rom_data[7:6] == 2'b11;
`else
  assign w_trap = 1'b0;
`endif
  always_comb begin
    w_next = r_state;
    case (r_state)
      FETCH_OP:  w_next = w_trap ? HALTED : w_need_imm ? FETCH_IMM : ISSUE;
      FETCH_IMM: w_next = ISSUE;
      ISSUE:     w_next = !ins_ready ? ISSUE : r_opcode == 4'd3 ? HALTED : FETCH_OP;
      default:   w_next = HALTED;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state   <= FETCH_OP;
      r_pc      <= RESET_PC;
      r_opcode  <= '0;
      r_dst     <= '0;
      r_src     <= '0;
      r_imm     <= '0;
      r_has_imm <= 1'b0;
      r_ins_pc  <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == FETCH_OP) begin
        r_opcode  <= rom_data[7:4];
        r_dst     <= rom_data[3:2];
        r_src     <= rom_data[1:0];
        r_imm     <= '0;
        r_has_imm <= 1'b0;
        r_ins_pc  <= r_pc;
        r_illegal <= w_trap;
        r_pc      <= r_pc + 8'd1;
      end
      if (r_state == FETCH_IMM) begin
        r_imm     <= rom_data;
        r_has_imm <= 1'b1;
        r_pc      <= r_pc + 8'd1;
      end
    end
  assign rom_addr    = r_pc;
  assign ins_valid   = r_state == ISSUE;
  assign halted      = r_state == HALTED;
  assign illegal     = r_illegal;
  assign ins_opcode  = r_opcode;
  assign ins_dst     = r_dst;
  assign ins_src     = r_src;
  assign ins_imm     = r_imm;
  assign ins_has_imm = r_has_imm;
  assign ins_pc      = r_ins_pc;
endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: random and directed programs checked against an instruction-level model of the fetch unit.
module tb_ifetch;
  logic        clk = 1'b0, rst = 1'b1, ins_ready = 1'b0;
  logic [7:0]  rom_addr, rom_data, ins_imm, ins_pc;
  logic [3:0]  ins_opcode;
  logic [1:0]  ins_dst, ins_src;
  logic        ins_valid, ins_has_imm, halted, illegal;
  logic [7:0]  rom [256];
  logic [24:0] obs;
  logic [24:0] iss [$];
  logic [7:0]  m_pc;
  bit          m_halt, m_ill, was_valid;
  int          g, total = 0, bad = 0;
  ifetch dut (
    .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_data(rom_data), .ins_ready(ins_ready),
    .ins_valid(ins_valid), .ins_opcode(ins_opcode), .ins_dst(ins_dst), .ins_src(ins_src),
    .ins_imm(ins_imm), .ins_has_imm(ins_has_imm), .ins_pc(ins_pc), .halted(halted), .illegal(illegal)
  );
  assign rom_data = rom[rom_addr];
  assign obs = {ins_opcode, ins_dst, ins_src, ins_imm, ins_has_imm, ins_pc};
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic bit needs_imm(input logic [7:0] b);
    return b[1:0] == 2'd0 && b[7:4] != 4'd3 && b[7:4] != 4'd7;
  endfunction
  function automatic bit trap_op(input logic [7:0] b);
`ifdef IFETCH_ILLEGAL_TRAP_EN
    return b[7:4] >= 4'd12;
`else
    return b[7:4] > 4'd15;
`endif
  endfunction
  // expected issue record for the instruction whose opcode byte sits at pc
  function automatic logic [24:0] expect_at(input logic [7:0] pc);
    logic [7:0] b, nx;
    bit h;
    b = rom[pc];
    nx = pc + 8'd1;
    h = needs_imm(b);
    return {b[7:4], b[3:2], b[1:0], h ? rom[nx] : 8'd0, h, pc};
  endfunction
  task automatic step(input int mode);
    logic [24:0] e;
    int len;
    @(negedge clk);
    e = expect_at(m_pc);
    len = e[8] ? 2 : 1;
    if (!m_halt && trap_op(rom[m_pc]) && g >= 1) begin
      m_halt = 1'b1;
      m_ill = 1'b1;
      m_pc = m_pc + 8'd1;
    end
    check("status", 32'({halted, illegal}), 32'({m_halt, m_ill}));
    if (m_halt) begin
      check("halt_valid", 32'(ins_valid), 32'd0);
      check("halt_addr", 32'(rom_addr), 32'(m_pc));
    end else if (ins_valid) begin
      if (!was_valid) check("latency", g, len);
      check("fields", 32'(obs), 32'(e));
      check("issue_addr", 32'(rom_addr), 32'(8'(m_pc + 8'(len))));
    end else g++;
    was_valid = ins_valid;
    ins_ready = mode == 1 ? 1'b1 : mode == 2 ? 1'b0 : ($urandom_range(0, 3) != 0);
    if (!m_halt && ins_valid && ins_ready) begin
      iss.push_back(obs);
      was_valid = 1'b0;
      g = 0;
      if (e[24:21] == 4'd3) m_halt = 1'b1;
      m_pc = m_pc + 8'(len);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    ins_ready = 1'b0;
    #1;
    check("rst_valid", 32'(ins_valid), 32'd0);
    check("rst_addr", 32'(rom_addr), 32'd0);
    check("rst_status", 32'({halted, illegal}), 32'd0);
    check("rst_fields", 32'(obs), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_pc = 8'd0;
    m_halt = 1'b0;
    m_ill = 1'b0;
    g = 1;
    was_valid = 1'b0;
    iss.delete();
  endtask
  task automatic run_until(input int n, input int mode, input int limit);
    for (int i = 0; i < limit && iss.size() < n && !m_halt; i++) step(mode);
    if (iss.size() < n && !m_halt) check("timeout", 32'(iss.size()), 32'(n));
  endtask
  initial begin
    logic [7:0] prog [22];
    prog = '{8'h08, 8'h0F, 8'h04, 8'h06, 8'h09, 8'h16, 8'h29, 8'h04, 8'h80, 8'h25, 8'h70,
             8'h58, 8'h33, 8'h19, 8'h19, 8'h19, 8'h19, 8'h19, 8'h19, 8'h19, 8'h19, 8'h30};
    for (int i = 0; i < 256; i++) rom[i] = i < 22 ? prog[i] : 8'hFF;
    // standard program with backpressure on MOV AX,6 and a final HALT
    do_reset();
    run_until(1, 1, 20);
    repeat (8) step(2);
    check("bp_valid", 32'(ins_valid), 32'd1);
    check("bp_addr", 32'(rom_addr), 32'd4);
    check("bp_fields", 32'(obs), 32'({4'd0, 2'd1, 2'd0, 8'd6, 1'b1, 8'd2}));
    run_until(100, 1, 100);
    check("first_issue", 32'(iss[0]), 32'({4'd0, 2'd2, 2'd0, 8'd15, 1'b1, 8'd0}));
    check("fifth_issue", 32'(iss[4]), 32'({4'd2, 2'd2, 2'd1, 8'd0, 1'b0, 8'd6}));
    repeat (22) step(0);
    check("halt_final", 32'({halted, ins_valid, rom_addr}), 32'({1'b1, 1'b0, 8'd22}));
    // reset landing in FETCH_IMM discards the pending instruction
    do_reset();
    @(posedge clk);
    #2 check("pre_rst_addr", 32'(rom_addr), 32'd1);
    rst = 1'b1;
    #1 check("mid_rst", 32'({ins_valid, rom_addr}), 32'd0);
    do_reset();
    run_until(1, 0, 40);
    check("post_rst_pc", 32'(iss[0][7:0]), 32'd0);
    // wrap: 255 NOTs then an immediate fetched across 8'hFF -> 8'h00
    for (int i = 0; i < 256; i++) rom[i] = i < 255 ? 8'h70 : 8'h04;
    do_reset();
    run_until(256, 1, 800);
    check("wrap_issue", 32'(iss[255]), 32'({4'd0, 2'd1, 2'd0, 8'h70, 1'b1, 8'd255}));
    @(negedge clk);
    check("wrap_fetch", 32'(rom_addr), 32'd1);
    // undefined opcode 12
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    rom[0] = 8'hC4;
    rom[1] = 8'h5A;
    do_reset();
    run_until(1, 1, 10);
`ifdef IFETCH_ILLEGAL_TRAP_EN
    check("c4_trap", 32'({halted, illegal, ins_valid, iss.size() == 0}), 32'b1101);
`else
    check("c4_issue", 32'(iss[0]), 32'({4'd12, 2'd1, 2'd0, 8'h5A, 1'b1, 8'd0}));
`endif
    // random programs with random ready
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
      do_reset();
      repeat (200) step(0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter RESET_PC, default 8'd0, program-counter value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 rom_addr  output  8  program-counter address driven to the instruction ROM.
REQ-005 rom_data  input  8  ROM byte, combinationally valid in the same cycle as rom_addr.
REQ-006 ins_ready  input  1  downstream execute stage accepts the issued instruction.
REQ-007 ins_valid  output  1  issued instruction fields are valid.
REQ-008 ins_opcode  output  4  opcode, rom byte [7:4].
REQ-009 ins_dst  output  2  destination field [3:2]: 1=AX, 2=DX.
REQ-010 ins_src  output  2  source field [1:0]: 0=immediate/none, 1=AX, 2=DX.
REQ-011 ins_imm  output  8  immediate byte; 0 when ins_has_imm=0.
REQ-012 ins_has_imm  output  1  the instruction carried a trailing immediate byte.
REQ-013 ins_pc  output  8  address of the opcode byte of the issued instruction.
REQ-014 halted  output  1  fetch stopped after a HALT was accepted.
REQ-015 illegal  output  1  fetch stopped on an undefined opcode (see Configuration).

Function
REQ-016 The FSM SHALL have the states FETCH_OP, FETCH_IMM, ISSUE and HALTED; rom_addr SHALL equal pc at all times.
REQ-017 FETCH_OP: latch rom_data into opcode/dst/src, record ins_pc=pc, pc<=pc+1; go to FETCH_IMM if an immediate is needed, else to ISSUE.
REQ-018 An immediate SHALL be needed iff src==0 and opcode is neither 3 (HALT) nor 7 (NOT).
REQ-019 FETCH_IMM: latch rom_data into ins_imm, set ins_has_imm=1, pc<=pc+1, go to ISSUE.
REQ-020 ISSUE: ins_valid=1; all ins_* outputs SHALL stay constant until the cycle in which ins_ready=1.
REQ-021 On acceptance in ISSUE: opcode 3 -> HALTED; otherwise -> FETCH_OP in the next cycle.
REQ-022 Latency: ins_valid SHALL rise 1 cycle after entering FETCH_OP without an immediate and 2 cycles after with one; throughput is at most 1 instruction per 2 or 3 cycles respectively.
REQ-023 HALTED: ins_valid=0, halted=1, pc frozen at HALT address+1; the state SHALL persist until reset.
REQ-024 pc SHALL wrap 8'hFF -> 8'h00 modulo 256, including an immediate fetched across the wrap.
REQ-025 ins_valid SHALL be 0 in FETCH_OP, FETCH_IMM and HALTED.
REQ-026 ins_ready SHALL be ignored outside ISSUE.

Reset
REQ-027 Asserting rst SHALL immediately set pc=RESET_PC, state=FETCH_OP, ins_valid=0, halted=0, illegal=0 and all ins_* fields to 0.
REQ-028 Reset SHALL take effect in any state, including mid-FETCH_IMM and in ISSUE with ready low; the pending instruction SHALL be discarded.
REQ-029 After rst deasserts, the first opcode fetch SHALL occur at the first rising clk edge.

Configuration
REQ-030 Macro IFETCH_ILLEGAL_TRAP_EN: when defined, opcodes 12-15 SHALL NOT be issued; FETCH_OP SHALL go directly to HALTED with illegal=1, halted=1, pc frozen at opcode address+1.
REQ-031 When IFETCH_ILLEGAL_TRAP_EN is undefined, opcodes 12-15 SHALL be issued as ordinary instructions following REQ-018, and illegal SHALL be tied to 0.

Verification
REQ-032 Standard program from reset: first issue opcode=0, dst=2, src=0, imm=15, has_imm=1, pc=0; the fifth issue at pc=6 is opcode=2, dst=2, src=1, has_imm=0.
REQ-033 Backpressure: ins_ready low for 5 cycles on the MOV AX,6 issue -> ins_valid held high, fields constant, rom_addr held at 4.
REQ-034 HALT: byte 8'h30 at address 21, accepted -> next cycle halted=1, ins_valid=0, rom_addr=22 for 20+ further cycles.
REQ-035 Wrap: addresses 0-254 hold 8'h70 (NOT) and address 255 holds 8'h04 -> issue pc=255, imm=8'h70; next opcode fetch at rom_addr=1.
REQ-036 rst pulse while in FETCH_IMM -> ins_valid=0 immediately; rom_addr=0 while rst is high; first issue after release is pc=0.
REQ-037 Byte 8'hC4 at address 0 -> with IFETCH_ILLEGAL_TRAP_EN: illegal=1, halted=1, no issue; without it: issue opcode=12, imm=rom[1].
